// File: rtl/convolucion_p3.sv
`default_nettype none
// ============================================================================
// Module   : convolucion_p3
// Purpose  : Convolution / cross-correlation engine. Reads Y and H from two
//            single-clock RAMs (1-cycle read latency), multiply-accumulates
//            every tap of each output sample and writes saturated Z samples
//            to an external RAM, one sample per WRITE cycle.
// Ports    : clk, rst (async, active-low)
//            start_i, mode_i, size_y_i, size_h_i   - run request
//            data_y_i, data_h_i                    - Y/H RAM read data
//            mem_y_addr_o, mem_h_addr_o            - Y/H RAM read addresses
//            data_z_o, mem_z_addr_o, write_o       - Z RAM write port
//            busy_o, done_o, err_o, ovf_o          - status
// Revision : 1.0 - initial release
// ============================================================================
module convolucion_p3 #(
  parameter int DATA_WIDTH        = 8,
  parameter int DATA_WIDTH_OUT    = 16,
  parameter int ADDRESS_WIDTH     = 5,
  parameter int ADDRESS_WIDTH_OUT = 6,
  parameter int SIGNED            = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         mode_i,
  input  logic [ADDRESS_WIDTH-1:0]     size_y_i,
  input  logic [ADDRESS_WIDTH-1:0]     size_h_i,
  input  logic [DATA_WIDTH-1:0]        data_y_i,
  input  logic [DATA_WIDTH-1:0]        data_h_i,
  output logic [ADDRESS_WIDTH-1:0]     mem_y_addr_o,
  output logic [ADDRESS_WIDTH-1:0]     mem_h_addr_o,
  output logic [DATA_WIDTH_OUT-1:0]    data_z_o,
  output logic [ADDRESS_WIDTH_OUT-1:0] mem_z_addr_o,
  output logic                         write_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic                         ovf_o
);

  // Accumulator is wide enough that a full run can never wrap.
  localparam int ACC_W = 2 * DATA_WIDTH + ADDRESS_WIDTH;
  localparam int AW    = ADDRESS_WIDTH;
  localparam int NW    = ADDRESS_WIDTH_OUT;
  localparam int OW    = DATA_WIDTH_OUT;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ADDR  = 3'd2,
    S_MAC   = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [AW-1:0]     ny_q, ny_d;
  logic [AW-1:0]     nh_q, nh_d;
  logic [NW-1:0]     n_q, n_d;
  logic [AW-1:0]     k_q, k_d;
  logic [AW-1:0]     kmax_q, kmax_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [AW-1:0]     y_addr_q, y_addr_d;
  logic [AW-1:0]     h_addr_q, h_addr_d;
  logic [OW-1:0]     z_data_q, z_data_d;
  logic [NW-1:0]     z_addr_q, z_addr_d;
  logic              write_q, write_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  // Index arithmetic is done at Z-address width so n - Ny + 1 etc. fit.
  logic [NW-1:0]     ny_ext, nh_ext, kmin_full, kmax_full, last_n;
  logic [ACC_W-1:0]  prod;
  logic [ACC_W-1:0]  acc_sum;
  logic [OW-1:0]     sat_val;
  logic              sat_clamp;

  assign ny_ext    = NW'(ny_q);
  assign nh_ext    = NW'(nh_q);
  // First tap whose Y index n-k is still inside Y.
  assign kmin_full = (n_q >= ny_ext) ? (n_q - ny_ext + NW'(1)) : '0;
  // Last tap: bounded by both n (Y index >= 0) and the H length.
  assign kmax_full = (n_q < (nh_ext - NW'(1))) ? n_q : (nh_ext - NW'(1));
  assign last_n    = ny_ext + nh_ext - NW'(2);

  // --------------------------------------------------------------------------
  // Multiplier, extended to accumulator width in the operand domain
  // --------------------------------------------------------------------------
  generate
    if (SIGNED != 0) begin : g_mul_signed
      logic signed [2*DATA_WIDTH-1:0] p;
      assign p    = $signed(data_h_i) * $signed(data_y_i);
      assign prod = {{(ACC_W-2*DATA_WIDTH){p[2*DATA_WIDTH-1]}}, p};
    end else begin : g_mul_unsigned
      logic [2*DATA_WIDTH-1:0] p;
      assign p    = data_h_i * data_y_i;
      assign prod = {{(ACC_W-2*DATA_WIDTH){1'b0}}, p};
    end
  endgenerate

  assign acc_sum = acc_q + prod;

  // --------------------------------------------------------------------------
  // Output saturation of the final accumulator value
  // --------------------------------------------------------------------------
  generate
    if (ACC_W <= OW) begin : g_sat_none
      // Output is at least as wide as the accumulator: never clamps.
      if (SIGNED != 0) begin : g_ext_signed
        assign sat_val = {{(OW-ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
      end else begin : g_ext_unsigned
        assign sat_val = {{(OW-ACC_W){1'b0}}, acc_sum};
      end
      assign sat_clamp = 1'b0;
    end else if (SIGNED != 0) begin : g_sat_signed
      // Fits when all bits from the output sign bit upward agree.
      logic [ACC_W-OW:0] top;
      assign top       = acc_sum[ACC_W-1:OW-1];
      assign sat_clamp = !((&top) || !(|top));
      assign sat_val   = !sat_clamp        ? acc_sum[OW-1:0] :
                         acc_sum[ACC_W-1]  ? {1'b1, {(OW-1){1'b0}}} :
                                             {1'b0, {(OW-1){1'b1}}};
    end else begin : g_sat_unsigned
      assign sat_clamp = |acc_sum[ACC_W-1:OW];
      assign sat_val   = sat_clamp ? {OW{1'b1}} : acc_sum[OW-1:0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    ny_d     = ny_q;
    nh_d     = nh_q;
    n_d      = n_q;
    k_d      = k_q;
    kmax_d   = kmax_q;
    acc_d    = acc_q;
    y_addr_d = y_addr_q;
    h_addr_d = h_addr_q;
    z_data_d = z_data_q;
    z_addr_d = z_addr_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    write_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d = mode_i;
          ny_d   = size_y_i;
          nh_d   = size_h_i;
          n_d    = '0;
          err_d  = 1'b0;
          ovf_d  = 1'b0;
          if ((size_y_i == '0) || (size_h_i == '0)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        acc_d   = '0;
        k_d     = AW'(kmin_full);
        kmax_d  = AW'(kmax_full);
        state_d = S_ADDR;
      end
      S_ADDR: begin
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_sum;
        if (k_q == kmax_q) begin
          // Sample complete: present it to the Z RAM in the WRITE cycle.
          write_d  = 1'b1;
          z_addr_d = n_q;
          z_data_d = sat_val;
          if (sat_clamp) ovf_d = 1'b1;
          state_d  = S_WRITE;
        end else begin
          k_d     = k_q + AW'(1);
          state_d = S_ADDR;
        end
      end
      S_WRITE: begin
        if (n_q == last_n) begin
          state_d = S_DONE;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = S_SETUP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Addresses are registered on entry to ADDR so they are stable for the
    // whole ADDR cycle; the RAM returns data during the following MAC cycle.
    if (state_d == S_ADDR) begin
      y_addr_d = AW'(n_q - NW'(k_d));
      h_addr_d = mode_d ? (nh_q - AW'(1) - k_d) : k_d;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      ny_q     <= '0;
      nh_q     <= '0;
      n_q      <= '0;
      k_q      <= '0;
      kmax_q   <= '0;
      acc_q    <= '0;
      y_addr_q <= '0;
      h_addr_q <= '0;
      z_data_q <= '0;
      z_addr_q <= '0;
      write_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      ny_q     <= ny_d;
      nh_q     <= nh_d;
      n_q      <= n_d;
      k_q      <= k_d;
      kmax_q   <= kmax_d;
      acc_q    <= acc_d;
      y_addr_q <= y_addr_d;
      h_addr_q <= h_addr_d;
      z_data_q <= z_data_d;
      z_addr_q <= z_addr_d;
      write_q  <= write_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign mem_y_addr_o = y_addr_q;
  assign mem_h_addr_o = h_addr_q;
  assign data_z_o     = z_data_q;
  assign mem_z_addr_o = z_addr_q;
  assign write_o      = write_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign ovf_o        = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_convolucion_p3.sv
`default_nettype none
// ============================================================================
// Module   : tb_convolucion_p3
// Purpose  : Self-checking bench for convolucion_p3. One unsigned and one
//            signed instance, each with its own Y/H RAM model. Vectors come
//            from a table; expected Z samples are queued when a run starts
//            and compared as the DUT writes them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_convolucion_p3;

  logic clk;
  logic rst;

  logic       start_s  [2];
  logic       mode_s   [2];
  logic [4:0] size_y_s [2];
  logic [4:0] size_h_s [2];
  logic [7:0] ydat     [2];
  logic [7:0] hdat     [2];
  logic [4:0] yaddr    [2];
  logic [4:0] haddr    [2];
  logic [15:0] dz      [2];
  logic [5:0] zaddr    [2];
  logic       wr       [2];
  logic       busy     [2];
  logic       done     [2];
  logic       err      [2];
  logic       ovf      [2];

  logic [7:0] ymem [2][32];
  logic [7:0] hmem [2][32];

  convolucion_p3 #(.SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst),
    .start_i(start_s[0]), .mode_i(mode_s[0]),
    .size_y_i(size_y_s[0]), .size_h_i(size_h_s[0]),
    .data_y_i(ydat[0]), .data_h_i(hdat[0]),
    .mem_y_addr_o(yaddr[0]), .mem_h_addr_o(haddr[0]),
    .data_z_o(dz[0]), .mem_z_addr_o(zaddr[0]), .write_o(wr[0]),
    .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]), .ovf_o(ovf[0])
  );

  convolucion_p3 #(.SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst),
    .start_i(start_s[1]), .mode_i(mode_s[1]),
    .size_y_i(size_y_s[1]), .size_h_i(size_h_s[1]),
    .data_y_i(ydat[1]), .data_h_i(hdat[1]),
    .mem_y_addr_o(yaddr[1]), .mem_h_addr_o(haddr[1]),
    .data_z_o(dz[1]), .mem_z_addr_o(zaddr[1]), .write_o(wr[1]),
    .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]), .ovf_o(ovf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-clock RAMs with one cycle of read latency.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      ydat[i] <= ymem[i][yaddr[i]];
      hdat[i] <= hmem[i][haddr[i]];
    end
  end

  typedef struct packed {
    logic              sgn;
    logic              mode;
    logic [4:0]        ny;
    logic [4:0]        nh;
    logic [7:0][7:0]   y;
    logic [7:0][7:0]   h;
    logic [4:0]        nz;
    logic [15:0][15:0] z;
    logic              ovf;
    logic              err;
  } vec_t;

  typedef struct packed {
    logic [5:0]  a;
    logic [15:0] d;
  } zexp_t;

  localparam int NT = 10;
  vec_t  tbl [NT];
  zexp_t q [$];
  zexp_t mon_e;
  int    n_vec  = 0;
  int    n_bad  = 0;
  int    wr_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic sgn, input logic mode, input int ny, input int nh,
                              input logic [63:0] y, input logic [63:0] h,
                              input logic [255:0] z, input int nz,
                              input logic ovf_e, input logic err_e);
    vec_t v;
    v.sgn = sgn; v.mode = mode; v.ny = 5'(ny); v.nh = 5'(nh);
    v.y = y; v.h = h; v.z = z; v.nz = 5'(nz); v.ovf = ovf_e; v.err = err_e;
    return v;
  endfunction

  // Reference model: scatter every Y*H product to its output index.
  function automatic vec_t make_vec(input logic sgn, input logic mode, input int ny, input int nh);
    vec_t v;
    int   acc [16];
    int   yv, hv, idx, lo, hi;
    v = '0;
    v.sgn = sgn; v.mode = mode; v.ny = 5'(ny); v.nh = 5'(nh);
    v.nz = 5'(ny + nh - 1);
    for (int j = 0; j < ny; j++) v.y[j] = 8'($urandom_range(0, 255));
    for (int i = 0; i < nh; i++) v.h[i] = 8'($urandom_range(0, 255));
    for (int n = 0; n < 16; n++) acc[n] = 0;
    for (int j = 0; j < ny; j++) begin
      for (int i = 0; i < nh; i++) begin
        yv  = sgn ? int'($signed(v.y[j])) : int'(v.y[j]);
        hv  = sgn ? int'($signed(v.h[i])) : int'(v.h[i]);
        idx = mode ? (j + nh - 1 - i) : (i + j);
        acc[idx] += hv * yv;
      end
    end
    lo = sgn ? -32768 : 0;
    hi = sgn ? 32767 : 65535;
    for (int n = 0; n < ny + nh - 1; n++) begin
      if (acc[n] > hi) begin acc[n] = hi; v.ovf = 1'b1; end
      if (acc[n] < lo) begin acc[n] = lo; v.ovf = 1'b1; end
      v.z[n] = 16'(acc[n]);
    end
    return v;
  endfunction

  // Scoreboard side: every Z write is matched against the queued expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr[i] === 1'b1) begin
        wr_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          mon_e = q.pop_front();
          chk("z_addr", 64'(zaddr[i]), 64'(mon_e.a));
          chk("z_data", 64'(dz[i]), 64'(mon_e.d));
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input bit poke);
    int s;
    int run;
    s = v.sgn ? 1 : 0;
    for (int a = 0; a < 32; a++) begin
      ymem[s][a] = (a < int'(v.ny)) ? v.y[a[2:0]] : 8'hA5;
      hmem[s][a] = (a < int'(v.nh)) ? v.h[a[2:0]] : 8'h5A;
    end
    for (int i = 0; i < int'(v.nz); i++) q.push_back({6'(i), v.z[i]});
    wr_cnt = 0;
    @(negedge clk);
    start_s[s] = 1'b1; mode_s[s] = v.mode; size_y_s[s] = v.ny; size_h_s[s] = v.nh;
    @(negedge clk);
    start_s[s] = 1'b0; size_y_s[s] = 5'd0; size_h_s[s] = 5'd0; mode_s[s] = 1'b0;
    chk("busy_after_start", 64'(busy[s]), 1);
    chk("err_after_start", 64'(err[s]), 64'(v.err));
    chk("ovf_cleared", 64'(ovf[s]), 0);
    run = 0;
    while (done[s] !== 1'b1 && run < 2000) begin
      run++;
      if (poke && run == 5) begin
        start_s[s] = 1'b1; mode_s[s] = ~v.mode; size_y_s[s] = 5'd3; size_h_s[s] = 5'd3;
      end else if (poke && run == 6) begin
        start_s[s] = 1'b0; mode_s[s] = 1'b0; size_y_s[s] = 5'd0; size_h_s[s] = 5'd0;
      end
      @(negedge clk);
    end
    if (done[s] !== 1'b1) begin
      chk("done_timeout", 0, 1);
      q.delete();
      return;
    end
    chk("run_length", 64'(run),
        v.err ? 0 : 64'(2 * int'(v.ny) * int'(v.nh) + 2 * (int'(v.ny) + int'(v.nh) - 1)));
    chk("busy_in_done", 64'(busy[s]), 1);
    chk("err_at_done", 64'(err[s]), 64'(v.err));
    chk("ovf_at_done", 64'(ovf[s]), 64'(v.ovf));
    chk("write_count", 64'(wr_cnt), 64'(v.nz));
    chk("queue_drained", 64'(q.size()), 0);
    q.delete();
    @(negedge clk);
    chk("done_pulse_width", 64'(done[s]), 0);
    chk("idle_after_done", 64'(busy[s]), 0);
    chk("ovf_held", 64'(ovf[s]), 64'(v.ovf));
    chk("err_held", 64'(err[s]), 64'(v.err));
  endtask

  initial begin
    int g;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; mode_s[i] = 1'b0; size_y_s[i] = 5'd0; size_h_s[i] = 5'd0;
      for (int a = 0; a < 32; a++) begin ymem[i][a] = 8'h00; hmem[i][a] = 8'h00; end
    end

    tbl[0] = mk(0, 0, 2, 4, 64'h0201, 64'h04030201,
                256'({16'd8, 16'd10, 16'd7, 16'd4, 16'd1}), 5, 0, 0);
    tbl[1] = mk(0, 1, 2, 4, 64'h0201, 64'h04030201,
                256'({16'd2, 16'd5, 16'd8, 16'd11, 16'd4}), 5, 0, 0);
    tbl[2] = mk(0, 0, 2, 3, 64'hFFFF, 64'hFFFFFF,
                256'({16'd65025, 16'd65535, 16'd65535, 16'd65025}), 4, 1, 0);
    tbl[3] = mk(0, 0, 2, 0, 64'h0201, 64'h0, 256'd0, 0, 0, 1);
    tbl[4] = mk(1, 0, 2, 2, 64'h02FF, 64'hFC03,
                256'({16'hFFF8, 16'd10, 16'hFFFD}), 3, 0, 0);
    tbl[5] = make_vec(0, 1, 5, 3);
    tbl[6] = make_vec(1, 0, 3, 4);
    tbl[7] = make_vec(0, 0, 1, 1);
    tbl[8] = make_vec(1, 1, 4, 4);
    tbl[9] = make_vec(0, 0, 8, 8);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_state",
          64'({yaddr[i], haddr[i], dz[i], zaddr[i], wr[i], busy[i], done[i], err[i], ovf[i]}), 0);
    end
    rst = 1'b1;
    @(negedge clk);

    for (int t = 0; t < NT; t++) run_vec(tbl[t], 1'b0);

    // Asynchronous reset in the MAC phase of Z sample 2.
    for (int a = 0; a < 32; a++) begin
      ymem[0][a] = (a < 2) ? tbl[0].y[a[2:0]] : 8'hA5;
      hmem[0][a] = (a < 4) ? tbl[0].h[a[2:0]] : 8'h5A;
    end
    for (int i = 0; i < 5; i++) q.push_back({6'(i), tbl[0].z[i]});
    wr_cnt = 0;
    @(negedge clk);
    start_s[0] = 1'b1; mode_s[0] = 1'b0; size_y_s[0] = 5'd2; size_h_s[0] = 5'd4;
    @(negedge clk);
    start_s[0] = 1'b0; size_y_s[0] = 5'd0; size_h_s[0] = 5'd0;
    g = 0;
    while (wr_cnt < 2 && g < 200) begin
      @(negedge clk); #1;
      g++;
    end
    chk("writes_before_reset", 64'(wr_cnt), 2);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_midrun_outputs",
        64'({yaddr[0], haddr[0], dz[0], zaddr[0], wr[0], busy[0], done[0], err[0], ovf[0]}), 0);
    q.delete();
    repeat (3) @(negedge clk);
    chk("reset_held_idle", 64'({wr[0], busy[0]}), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_restart_after_reset", 64'({wr[0], busy[0]}), 0);

    // Re-runs with a start pulse issued while busy; results must not change.
    run_vec(tbl[0], 1'b1);
    run_vec(tbl[4], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
